// File: rtl/rx_fifo.sv
// Receive-side byte FIFO behind the SPART receiver: issues the read strobe,
// captures the returned byte and buffers it for the bus-side consumer.
module rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rda,
    input  logic [7:0]    rx_data,
    output logic          rx_read,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          clr_ovf
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop_en;
    logic            ovf_set;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign dout    = mem[rd_ptr];
    assign push    = (state == CAPTURE);
    assign pop_en  = pop && !empty;
    assign ovf_set = (state == IDLE) && rda && full;

    // NOTE: every output of a combinational block is given a default before
    // the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rda && !full) state_nxt = READ;
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rx_read <= 1'b0;
        end else begin
            state   <= state_nxt;
            rx_read <= (state_nxt == READ);
        end
    end

    // NOTE: the storage array carries no reset; the pointers and count
    // define which entries are meaningful, so clearing data buys nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else        ovf <= ovf_set | (ovf & ~clr_ovf);
    end

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: a queue-based receiver model feeds bytes,
// a scoreboard queue holds expected bytes and a monitor checks every pop.
module tb_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          rda;
    logic [7:0]    rx_data;
    logic          rx_read;
    logic          pop;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          ovf;
    logic          clr_ovf;

    int total = 0;
    int bad   = 0;
    int rd_pulses = 0;

    logic [7:0] rx_pend [$];
    logic [7:0] exp_q   [$];

    rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rda     (rda),
        .rx_data (rx_data),
        .rx_read (rx_read),
        .pop     (pop),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Receiver model: a byte is available while anything is pending; a read
    // strobe hands the head byte over, valid for the following cycle.
    initial begin
        rda     = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rx_read) begin
                rd_pulses++;
                if (rx_pend.size() > 0) rx_data = rx_pend.pop_front();
            end
            rda = (rx_pend.size() > 0);
        end
    end

    // Monitor: every accepted pop must present the oldest outstanding byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (count > DEPTH) check("count_bound", 32'(count), DEPTH);
                if (pop && !empty) begin
                    if (exp_q.size() == 0) check("pop_unexpected", 32'(dout), 32'hFFFF_FFFF);
                    else                   check("pop_data", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_pend.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int target, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (count == target) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, 32'(count), 32'(target));
        if (!hit) $display("FAIL %s: count target not reached in %0d cycles", name, budget);
    endtask

    task automatic wait_read_negedge(input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rx_read) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, 32'(hit), 1);
    endtask

    task automatic drain(input string name);
        pop = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            tick();
            if (empty && exp_q.size() == 0) break;
        end
        pop = 1'b0;
        check(name, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit hit;
        rst_n   = 1'b0;
        pop     = 1'b0;
        clr_ovf = 1'b0;
        repeat (2) tick();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_rx_read", 32'(rx_read), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while the read strobe is high.
        send_byte(8'h3C);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_read) begin
                hit = 1'b1;
                break;
            end
        end
        check("mid_read_reached", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx_read", 32'(rx_read), 0);
        tick();
        rst_n = 1'b1;
        check("rel_count", 32'(count), 0);
        check("rel_empty", 32'(empty), 1);
        check("rel_ovf", 32'(ovf), 0);
        wait_count(1, 20, "rst_pending_captured");
        check("rst_pending_dout", 32'(dout), 32'h3C);
        drain("drain_rst");

        // Single byte: latency and strobe count.
        p0 = rd_pulses;
        send_byte(8'hA5);
        wait_read_negedge("single_read_seen");
        @(negedge clk);
        check("single_count_capture", 32'(count), 0);
        @(negedge clk);
        check("single_count_after", 32'(count), 1);
        check("single_dout", 32'(dout), 32'hA5);
        repeat (3) @(negedge clk);
        check("single_pulses", 32'(rd_pulses - p0), 1);
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("single_empty", 32'(empty), 1);

        // Full and overflow.
        for (int i = 0; i < DEPTH; i++) send_byte(8'h80 + 8'(i));
        wait_count(DEPTH, 120, "fill_count");
        check("fill_full", 32'(full), 1);
        p0 = rd_pulses;
        send_byte(8'hEE);
        repeat (4) tick();
        check("ovf_no_read", 32'(rd_pulses - p0), 0);
        check("ovf_set", 32'(ovf), 1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        wait_read_negedge("ovf_read_after_pop");
        wait_count(DEPTH, 10, "refill_count");
        check("refill_full", 32'(full), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(ovf), 0);
        drain("drain_full");

        // Order across pointer wrap with random pops.
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        hit = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            pop = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0) begin
                hit = 1'b1;
                break;
            end
        end
        pop = 1'b0;
        check("wrap_all_popped", 32'(hit), 1);
        tick();
        check("wrap_empty", 32'(empty), 1);

        // Push and pop together at count 3.
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i));
        wait_count(3, 40, "sim_prefill");
        send_byte(8'h43);
        wait_read_negedge("sim_read_seen");
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("sim_count3", 32'(count), 3);
        check("sim_head", 32'(dout), 32'h41);
        drain("drain_sim3");

        // Push and pop together at count 0: the pop is ignored.
        send_byte(8'h5A);
        wait_read_negedge("sim0_read_seen");
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("sim0_count", 32'(count), 1);
        check("sim0_dout", 32'(dout), 32'h5A);
        drain("drain_sim0");

        // Pops while empty leave everything untouched.
        pop = 1'b1;
        repeat (4) tick();
        pop = 1'b0;
        check("epop_count", 32'(count), 0);
        check("epop_empty", 32'(empty), 1);
        check("epop_ovf", 32'(ovf), 0);
        send_byte(8'h77);
        wait_count(1, 20, "epop_push");
        check("epop_dout", 32'(dout), 32'h77);
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
